pll_lock_monitor: RTL
=====================

# pll_lock_monitor

Consumes the PLL lock indication and turns it into the design's system reset and ready status. Synchronizes `locked_in` into the PLL output clock domain, qualifies it as stable for a programmable time, holds reset for a further programmable time, and then releases the system. Detects loss of lock afterwards, immediately re-asserts system reset, and records the event. Sits directly downstream of `pll_core`; every other block takes its reset from `sys_reset_out`.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `locked_in`; minimum 2.
- `STABLE_CYCLES`, 1024: consecutive cycles of synchronized lock required; minimum 1.
- `HOLD_CYCLES`, 16: extra cycles `sys_reset_out` stays high after qualification; minimum 1.
- `CNT_W`, 8: width of the lock-loss counter.
- `clock` in 1: PLL output clock (`pll_core.clock_out`). One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `locked_in` in 1: PLL lock (`pll_core.locked`); treated as asynchronous.
- `clear_in` in 1: single-cycle pulse; clears `lost_sticky_out` and `lost_count_out`.
- `sys_reset_out` out 1: registered system reset, active-high.
- `ready_out` out 1: high only in RUN.
- `lost_sticky_out` out 1: set on any lock loss after qualification.
- `lost_count_out` out CNT_W: saturating lock-loss count (see Configuration).
- `state_out` out 3: current FSM state encoding, for debug.

## Operation
- Reset values: `sys_reset_out`=1, `ready_out`=0, `lost_sticky_out`=0, `lost_count_out`=0, state WAIT_LOCK, synchronizer flops 0, counters 0.
- `locked_s` is the last synchronizer stage output.
- States:
  - WAIT_LOCK: `sys_reset_out`=1. Goes to STABILIZE when `locked_s`=1, with the cycle counter cleared.
  - STABILIZE: counts cycles with `locked_s`=1. Goes to HOLD when the counter reaches `STABLE_CYCLES`-1. If `locked_s`=0, returns to WAIT_LOCK; this is not a loss event.
  - HOLD: `sys_reset_out`=1. Goes to RUN after `HOLD_CYCLES` cycles. If `locked_s`=0, returns to WAIT_LOCK and this is a loss event.
  - RUN: `sys_reset_out`=0 and `ready_out`=1. If `locked_s`=0, returns to WAIT_LOCK and this is a loss event.
- Loss event:
  - `lost_sticky_out` is set to 1.
  - `lost_count_out` increments and saturates at all-ones (2^CNT_W-1).
- `clear_in` and a loss event in the same cycle: the loss wins. Sticky ends at 1; count ends at 1, cleared then incremented.
- `clear_in` never changes the FSM or `sys_reset_out`.
- Glitches on `locked_in` shorter than one cycle may be missed. Any glitch that reaches `locked_s` restarts qualification.
- Counters are sized to `$clog2` of their maximum count and never wrap.

## Timing
- Let edge k be the first edge at which synchronizer stage 1 captures `locked_in`=1, with `locked_in` held high afterwards.
- `sys_reset_out` falls and `ready_out` rises after edge k+`SYNC_STAGES`+`STABLE_CYCLES`+`HOLD_CYCLES`.
- Let edge m be the first edge at which stage 1 captures `locked_in`=0 while in RUN. After edge m+`SYNC_STAGES`:
  - `sys_reset_out`=1 and `ready_out`=0;
  - sticky and count are updated;
  - the state is WAIT_LOCK.
- `clear_in` takes effect on the edge it is sampled. Outputs read 0 on the following cycle.
- Async `reset` mid-operation forces all reset values immediately, including `sys_reset_out`=1. Release does not depend on `locked_in`. After release, qualification restarts from WAIT_LOCK.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PLL_LOCK_MONITOR_COUNT_EN` defined: the `lost_count_out` counter is implemented as described.
- `PLL_LOCK_MONITOR_COUNT_EN` undefined: no counter logic; `lost_count_out` is tied to 0.
- The sticky flag and the FSM are identical in both builds.

## Structure
- Package `pll_lock_pkg` holds:
  - the state typedef: WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3;
  - the default parameter constants.
- Sub-module `sync_bit`: an N-stage flop synchronizer with async active-high reset to 0, parameterized by `SYNC_STAGES`.

## Test plan
Benches run with `SYNC_STAGES`=2, `STABLE_CYCLES`=8, `HOLD_CYCLES`=4, `CNT_W`=2.
- Lock from reset: raise `locked_in` before edge k. Required: `sys_reset_out` stays 1 through edge k+13 and is 0 after edge k+14; `ready_out`=1.
- Unstable lock: pulse `locked_in` high for 5 cycles, then low. Required: FSM back in WAIT_LOCK, `sys_reset_out` still 1, sticky=0, count=0.
- Loss in RUN: drop `locked_in` at edge m. Required: `sys_reset_out`=1 after edge m+2, sticky=1, count=1; relocking releases reset again after 14 edges.
- Saturation: 5 loss events. Required: `lost_count_out`=3. Then pulse `clear_in`. Required: count=0, sticky=0, FSM unaffected.
- Clear with loss in the same cycle: required sticky=1, count=1.
- Async reset in HOLD: assert `reset` between edges. Required: all outputs return to reset values immediately, with no clock edge needed. Build without the macro: `lost_count_out`=0 throughout all scenarios.

Source files
------------

// File: rtl/pll_lock_pkg.sv
// Shared types and default parameters for the PLL lock monitor.
package pll_lock_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILIZE = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_HOLD_CYCLES   = 16;
  localparam int unsigned DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_bit.sv
// N-stage flop synchronizer for a single asynchronous bit, reset to 0.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
  end

  assign q_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies PLL lock, sequences the system reset release and records lock losses.
// Define PLL_LOCK_MONITOR_COUNT_EN to implement the saturating lost_count_out counter.
module pll_lock_monitor
  import pll_lock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked_in,
  input  logic             clear_in,
  output logic             sys_reset_out,
  output logic             ready_out,
  output logic             lost_sticky_out,
  output logic [CNT_W-1:0] lost_count_out,
  output logic [2:0]       state_out
);

  localparam int unsigned MAX_CNT = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  logic             locked_s;
  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             sticky_q, sticky_d;
  logic             loss_c;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_in  (locked_in),
    .q_out (locked_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      tmr_q       <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      sticky_q    <= sticky_d;
    end
  end

  // Next state; reset/ready are registered from the next state so they track state_q exactly.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    loss_c  = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
          tmr_d   = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (tmr_q == TMR_W'(STABLE_CYCLES - 1)) begin
          state_d = HOLD;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          loss_c  = 1'b1;
        end else if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          loss_c  = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    // A loss in the same cycle as a clear wins.
    sticky_d    = loss_c ? 1'b1 : (clear_in ? 1'b0 : sticky_q);
  end

`ifdef PLL_LOCK_MONITOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base_c;

  always_comb begin
    cnt_base_c = clear_in ? '0 : cnt_q;
    cnt_d      = cnt_base_c;
    if (loss_c && (cnt_base_c != '1)) cnt_d = cnt_base_c + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign lost_count_out = cnt_q;
`else
  assign lost_count_out = '0;
`endif

  assign sys_reset_out   = sys_reset_q;
  assign ready_out       = ready_q;
  assign lost_sticky_out = sticky_q;
  assign state_out       = state_q;

endmodule
